// File: rtl/spec_window_packer.sv
`default_nettype none
// spec_window_packer: keeps bins inside the latched window, prefixes each range bin with a header
// and drains the words through an output FIFO. Optional trailer/checksum: define SPW_CHECKSUM_EN.
module spec_window_packer #(
    parameter int          FFT_LEN    = 1024,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [15:0] HDR_SYNC   = 16'h5AA5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        frame_start_i,
    input  logic [63:0] data_i,
    input  logic        valid_i,
    input  logic [15:0] low_lim_i,
    input  logic [15:0] high_lim_i,
    input  logic [15:0] n_rangebins_i,
    output logic [15:0] y0_o,
    output logic [15:0] y0z_o,
    output logic [15:0] y1_o,
    output logic [15:0] y1z_o,
    output logic        valid_o,
    output logic        frame_done_o,
    output logic        overflow_o,
    output logic        seq_err_o
);
    localparam int            BW       = $clog2(FFT_LEN);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_LEN - 1);
    localparam logic [15:0]   MAX_HIGH = 16'(FFT_LEN - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

    logic [15:0]   low_q, high_q, nrb_q, frame_cnt, rb_idx;
    logic [BW-1:0] bin_idx;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nx;
    logic [CW-1:0] count;
    logic [63:0]   out_word;

    logic [15:0]   high_clamp, nrb_in, eff_low, eff_high, eff_nrb, eff_fc, eff_rb;
    logic [15:0]   bin16, win_len;
    logic [BW-1:0] eff_bin;
    logic          in_win, hdr_req, dat_req, trl_req, last_bin, last_rb, rd_en, drop;
    logic [63:0]   hdr_word, trl_word, word_a, word_b;
    logic [1:0]    n_req, n_acc;
    logic [CW:0]   free_slots;

    // A frame_start in the same cycle as valid_i makes that word bin 0 under the new limits.
    always_comb begin
        high_clamp = (high_lim_i > MAX_HIGH) ? MAX_HIGH : high_lim_i;
        nrb_in     = (n_rangebins_i == 16'd0) ? 16'd1 : n_rangebins_i;
        eff_low    = frame_start_i ? low_lim_i       : low_q;
        eff_high   = frame_start_i ? high_clamp      : high_q;
        eff_nrb    = frame_start_i ? nrb_in          : nrb_q;
        eff_fc     = frame_start_i ? frame_cnt + 16'd1 : frame_cnt;
        eff_rb     = frame_start_i ? 16'd0           : rb_idx;
        eff_bin    = frame_start_i ? '0              : bin_idx;
        bin16      = 16'(eff_bin);
        win_len    = (eff_low > eff_high) ? 16'd0 : eff_high - eff_low + 16'd1;
        in_win     = (bin16 >= eff_low) && (bin16 <= eff_high);
        hdr_req    = valid_i && (eff_bin == '0);
        dat_req    = valid_i && in_win;
        last_bin   = valid_i && (eff_bin == LAST_BIN);
        last_rb    = (eff_rb == eff_nrb - 16'd1);
        hdr_word   = {HDR_SYNC, eff_rb, win_len, eff_fc};
    end

`ifdef SPW_CHECKSUM_EN
    logic [15:0] xor_acc, xor_next;

    function automatic logic [15:0] lane_xor(input logic [63:0] w);
        return w[63:48] ^ w[47:32] ^ w[31:16] ^ w[15:0];
    endfunction

    always_comb begin
        xor_next = (hdr_req ? lane_xor(hdr_word) : xor_acc) ^ (dat_req ? lane_xor(data_i) : 16'd0);
        trl_req  = last_bin;
        trl_word = {16'hA55A, 32'd0, xor_next};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            xor_acc <= '0;
        else if (valid_i)
            xor_acc <= xor_next;
    end
`else
    assign trl_req  = 1'b0;
    assign trl_word = '0;
`endif

    // Up to two words per cycle; the read frees its slot before writes are admitted.
    always_comb begin
        n_req        = 2'(hdr_req) + 2'(dat_req) + 2'(trl_req);
        word_a       = hdr_req ? hdr_word : (dat_req ? data_i : trl_word);
        word_b       = hdr_req ? data_i : trl_word;
        rd_en        = (count != '0);
        free_slots   = DEPTH_W - {1'b0, count} + (CW+1)'(rd_en);
        n_acc        = (free_slots >= (CW+1)'(n_req)) ? n_req : free_slots[1:0];
        drop         = (n_acc != n_req);
        wr_ptr_nx    = wr_ptr + AW'(1);
        frame_done_o = last_bin && last_rb;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            low_q      <= '0;
            high_q     <= '0;
            nrb_q      <= '0;
            frame_cnt  <= '0;
            rb_idx     <= '0;
            bin_idx    <= '0;
            overflow_o <= 1'b0;
            seq_err_o  <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_word   <= '0;
            valid_o    <= 1'b0;
        end else begin
            if (frame_start_i) begin
                low_q     <= low_lim_i;
                high_q    <= high_clamp;
                nrb_q     <= nrb_in;
                frame_cnt <= frame_cnt + 16'd1;
                if (bin_idx != '0)
                    seq_err_o <= 1'b1;
            end
            if (valid_i) begin
                if (eff_bin == LAST_BIN) begin
                    bin_idx <= '0;
                    rb_idx  <= last_rb ? 16'd0 : eff_rb + 16'd1;
                end else begin
                    bin_idx <= eff_bin + BW'(1);
                    rb_idx  <= eff_rb;
                end
            end else if (frame_start_i) begin
                bin_idx <= '0;
                rb_idx  <= '0;
            end
            overflow_o <= (overflow_o && !frame_start_i) || drop;
            count      <= count + CW'(n_acc) - CW'(rd_en);
            wr_ptr     <= wr_ptr + AW'(n_acc);
            if (rd_en) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_word <= mem[rd_ptr];
            end
            valid_o <= rd_en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (n_acc != 2'd0)
            mem[wr_ptr] <= word_a;
        if (n_acc == 2'd2)
            mem[wr_ptr_nx] <= word_b;
    end

    assign y0_o  = out_word[63:48];
    assign y0z_o = out_word[47:32];
    assign y1_o  = out_word[31:16];
    assign y1z_o = out_word[15:0];

endmodule
`default_nettype wire
